// File: rtl/mux8_rr_arbiter.sv
// Round-robin burst arbiter driving the select/enable of an 8:1 single-bit mux, with registered mux output.
// Optional MUX_ARB_LOCK_EN adds a lock input that extends the current owner's burst.
module mux8_rr_arbiter #(
  parameter int NREQ      = 8,
  parameter int SEL_W     = 3,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  din,
`ifdef MUX_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             y,
  output logic             busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  state_t           state, state_nx;
  logic [NREQ-1:0]  gnt_nx;
  logic [SEL_W-1:0] sel_nx, ptr, ptr_nx;
  logic             en_nx, busy_nx;
  logic [CNT_W-1:0] beat_cnt, cnt_nx;
  logic             last_beat, lock_hold;
  pick_t            pick_idle, pick_rel;

  // First set bit of r, scanning upward from p with wrap.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] r, input logic [SEL_W-1:0] p);
    pick_t res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = SEL_W'((int'(p) + i) % NREQ);
      if (!res.found && r[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

  assign pick_idle = rr_pick(req, ptr);
  // On burst end the previous owner drops to lowest priority.
  assign pick_rel  = rr_pick(req, sel + SEL_W'(1));
  assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = lock & req[sel];
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    sel_nx   = sel;
    en_nx    = en;
    busy_nx  = busy;
    ptr_nx   = ptr;
    cnt_nx   = beat_cnt;
    case (state)
      IDLE: begin
        gnt_nx  = '0;
        en_nx   = 1'b0;
        busy_nx = 1'b0;
        if (pick_idle.found) begin
          state_nx = GRANT;
          gnt_nx   = NREQ'(1) << pick_idle.idx;
          sel_nx   = pick_idle.idx;
          en_nx    = 1'b1;
          busy_nx  = 1'b1;
          cnt_nx   = '0;
        end
      end
      GRANT: begin
        if (!req[sel] || last_beat) begin
          if (req[sel] && lock_hold) begin
            cnt_nx = '0;
          end else begin
            ptr_nx = sel + SEL_W'(1);
            if (pick_rel.found) begin
              gnt_nx = NREQ'(1) << pick_rel.idx;
              sel_nx = pick_rel.idx;
              en_nx  = 1'b1;
              busy_nx = 1'b1;
              cnt_nx = '0;
            end else begin
              state_nx = IDLE;
              gnt_nx   = '0;
              en_nx    = 1'b0;
              busy_nx  = 1'b0;
              cnt_nx   = '0;
            end
          end
        end else begin
          cnt_nx = beat_cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      en       <= 1'b0;
      busy     <= 1'b0;
      ptr      <= '0;
      beat_cnt <= '0;
      y        <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      sel      <= sel_nx;
      en       <= en_nx;
      busy     <= busy_nx;
      ptr      <= ptr_nx;
      beat_cnt <= cnt_nx;
      // Uses pre-edge sel/en, so y trails the grant by one cycle.
      y        <= en ? din[sel] : 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: BURST_LEN=4 instance plus a BURST_LEN=1 instance.
module tb_mux8_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, req1, din;
  logic [7:0] gnt, gnt1;
  logic [2:0] sel, sel1;
  logic       en, en1, y, y1, busy, busy1;
`ifdef MUX_ARB_LOCK_EN
  logic       lock;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
`ifdef MUX_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .sel(sel), .en(en), .y(y), .busy(busy));

  mux8_rr_arbiter #(.BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .din(din),
`ifdef MUX_ARB_LOCK_EN
    .lock(1'b0),
`endif
    .gnt(gnt1), .sel(sel1), .en(en1), .y(y1), .busy(busy1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'hFF; req1 = 8'hFF; din = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({gnt, sel, en, y, busy} !== 14'h0) begin
        bad++;
        $display("FAIL reset edge%0d: gnt=%h sel=%0d en=%b y=%b busy=%b, want all 0", i, gnt, sel, en, y, busy);
      end
      total++;
      if ({gnt1, sel1, en1, y1, busy1} !== 14'h0) begin
        bad++;
        $display("FAIL reset1 edge%0d: gnt=%h sel=%0d en=%b y=%b busy=%b, want all 0", i, gnt1, sel1, en1, y1, busy1);
      end
    end
    rst_n = 1'b1; req = 8'h00; req1 = 8'h00; din = 8'h00;
    tick();
    total++;
    if ({gnt, en, busy} !== 10'h0) begin
      bad++;
      $display("FAIL idle_after_reset: gnt=%h en=%b busy=%b, want 0", gnt, en, busy);
    end
  endtask

  task automatic test_single_owner();
    do_reset();
    req = 8'h20;
    tick();
    total++;
    if (gnt !== 8'h20 || sel !== 3'd5 || en !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: gnt=%h sel=%0d en=%b busy=%b, want 20/5/1/1", gnt, sel, en, busy);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (gnt !== 8'h20 || en !== 1'b1) begin
        bad++;
        $display("FAIL single_hold cyc%0d: gnt=%h en=%b, want 20/1", i, gnt, en);
      end
    end
    req = 8'h00;
    tick();
    total++;
    if (gnt !== 8'h00 || en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_release: gnt=%h en=%b busy=%b, want 0/0/0", gnt, en, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp;
    do_reset();
    req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      for (int b = 0; b < 4; b++) begin
        exp = 8'h01 << (k % 8);
        total++;
        if (gnt !== exp || sel !== 3'(k % 8) || en !== 1'b1) begin
          bad++;
          $display("FAIL rr k%0d b%0d: gnt=%h sel=%0d en=%b, want %h/%0d/1", k, b, gnt, sel, en, exp, k % 8);
        end
        // Non-owner request bits toggle without effect mid-burst.
        if (b == 1) req = 8'hFF ^ (8'h01 << ((k + 3) % 8));
        else req = 8'hFF;
        tick();
      end
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_early_release();
    do_reset();
    req = 8'h04;
    tick();
    total++;
    if (gnt !== 8'h04 || sel !== 3'd2) begin
      bad++;
      $display("FAIL er_grant: gnt=%h sel=%0d, want 04/2", gnt, sel);
    end
    req = 8'h84;
    tick();
    total++;
    if (gnt !== 8'h04) begin
      bad++;
      $display("FAIL er_beat1: gnt=%h, want 04", gnt);
    end
    req = 8'h80;
    tick();
    total++;
    if (gnt !== 8'h80 || sel !== 3'd7) begin
      bad++;
      $display("FAIL er_switch: gnt=%h sel=%0d, want 80/7", gnt, sel);
    end
    req = 8'h05;
    tick();
    total++;
    if (gnt !== 8'h01 || sel !== 3'd0) begin
      bad++;
      $display("FAIL er_wrap: gnt=%h sel=%0d, want 01/0", gnt, sel);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_data_path();
    do_reset();
    din = 8'hA5; req1 = 8'h03;
    tick();
    total++;
    if (gnt1 !== 8'h01 || sel1 !== 3'd0 || y1 !== 1'b0) begin
      bad++;
      $display("FAIL dp_first: gnt=%h sel=%0d y=%b, want 01/0/0", gnt1, sel1, y1);
    end
    tick();
    total++;
    if (gnt1 !== 8'h02 || sel1 !== 3'd1 || y1 !== 1'b1) begin
      bad++;
      $display("FAIL dp_second: gnt=%h sel=%0d y=%b, want 02/1/1", gnt1, sel1, y1);
    end
    tick();
    total++;
    if (gnt1 !== 8'h01 || y1 !== 1'b0) begin
      bad++;
      $display("FAIL dp_third: gnt=%h y=%b, want 01/0", gnt1, y1);
    end
    req1 = 8'h00;
    tick();
    tick();
    total++;
    if (en1 !== 1'b0 || y1 !== 1'b0) begin
      bad++;
      $display("FAIL dp_idle: en=%b y=%b, want 0/0", en1, y1);
    end
    din = 8'h00;
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    lock = 1'b1; req = 8'h08;
    tick();
    req = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (gnt !== 8'h08) begin
        bad++;
        $display("FAIL lock_hold cyc%0d: gnt=%h, want 08", i, gnt);
      end
      tick();
    end
    lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (gnt !== 8'h08) begin
        bad++;
        $display("FAIL lock_tail cyc%0d: gnt=%h, want 08", i, gnt);
      end
    end
    tick();
    total++;
    if (gnt !== 8'h10 || sel !== 3'd4) begin
      bad++;
      $display("FAIL lock_release: gnt=%h sel=%0d, want 10/4", gnt, sel);
    end
    req = 8'h00;
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0; req = '0; req1 = '0; din = '0;
`ifdef MUX_ARB_LOCK_EN
    lock = 1'b0;
`endif
    test_reset();
    test_single_owner();
    test_round_robin();
    test_early_release();
    test_data_path();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
